// File: rtl/mem_burst_pkg.sv
// Shared types for the memory-burst sequencer: FSM state encoding and burst mode values.
package mem_burst_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CS0  = 3'd1,
    DATA = 3'd2,
    CS1  = 3'd3,
    REDY = 3'd4
  } state_t;

  localparam logic MODE_WR = 1'b0;
  localparam logic MODE_RD = 1'b1;

endpackage

// File: rtl/mem_burst_seq_sync_bit.sv
// Single-bit synchroniser: SYNC-stage flop chain cleared by reset.
module sync_bit #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] chain_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[SYNC-2:0], d};
    end
  end

  assign q = chain_reg[SYNC-1];

endmodule

// File: rtl/mem_burst_seq.sv
// Memory-burst sequencer: chip-select setup, write/read burst of run-time length, hold gap,
// then a req/ack level handshake.
module mem_burst_seq
  import mem_burst_pkg::*;
#(
  parameter int AW    = 5,
  parameter int CW    = 6,
  parameter int SETUP = 3,
  parameter int HOLD  = 3,
  parameter int SYNC  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          mode,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] len,
  output logic          ack,
  output logic          busy,
  output logic          csn,
  output logic          we,
  output logic          re,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] st
);

  localparam logic [CW-1:0] SETUP_C = CW'(SETUP);
  localparam logic [CW-1:0] HOLD_C  = CW'(HOLD);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          mode_reg, mode_next;
  logic [AW-1:0] base_reg, base_next;
  logic [CW-1:0] len_reg, len_next;
  logic          rs;

  sync_bit #(.SYNC(SYNC)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req),
    .q   (rs)
  );

  // cnt_next defaults to zero so the counter clears on every state exit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    mode_next  = mode_reg;
    base_next  = base_reg;
    len_next   = len_reg;
    case (state_reg)
      IDLE: begin
        if (rs) begin
          state_next = CS0;
          mode_next  = mode;
          base_next  = base;
          len_next   = (len == '0) ? ONE_C : len;
        end
      end
      CS0: begin
        if (cnt_reg >= SETUP_C) state_next = DATA;
        else                    cnt_next   = cnt_reg + ONE_C;
      end
      DATA: begin
        // Losing req aborts after the beat in flight; the hold gap still runs.
        if ((cnt_reg >= len_reg - ONE_C) || !rs) state_next = CS1;
        else                                     cnt_next   = cnt_reg + ONE_C;
      end
      CS1: begin
        if (cnt_reg >= HOLD_C) state_next = rs ? REDY : IDLE;
        else                   cnt_next   = cnt_reg + ONE_C;
      end
      REDY: begin
        if (!rs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mode_reg  <= MODE_WR;
      base_reg  <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      base_reg  <= base_next;
      len_reg   <= len_next;
    end
  end

  // Memory-side outputs follow the state held before the edge, one cycle behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn  <= 1'b1;
      we   <= 1'b0;
      re   <= 1'b0;
      addr <= '0;
    end else begin
      csn <= !((state_reg == CS0) || (state_reg == DATA));
      we  <= (state_reg == DATA) && (mode_reg == MODE_WR);
      re  <= (state_reg == DATA) && (mode_reg == MODE_RD);
      if (state_reg == DATA) begin
        addr <= base_reg + AW'(cnt_reg);
      end
    end
  end

  assign ack  = (state_reg == REDY);
  assign busy = (state_reg != IDLE);
  assign st   = cnt_reg;

endmodule

// File: tb/tb_mem_burst_seq.sv
// Self-checking bench for mem_burst_seq: directed and random bursts measured against burst-level timing rules.
module tb_mem_burst_seq;

  localparam int AW    = 5;
  localparam int CW    = 6;
  localparam int SETUP = 3;
  localparam int HOLD  = 3;
  localparam int SYNC  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          mode;
  logic [AW-1:0] base;
  logic [CW-1:0] len;
  logic          ack, busy, csn, we, re;
  logic [AW-1:0] addr;
  logic [CW-1:0] st;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_burst_seq #(
    .AW(AW), .CW(CW), .SETUP(SETUP), .HOLD(HOLD), .SYNC(SYNC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .mode (mode),
    .base (base),
    .len  (len),
    .ack  (ack),
    .busy (busy),
    .csn  (csn),
    .we   (we),
    .re   (re),
    .addr (addr),
    .st   (st)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One burst from req rise to return to IDLE; abort_k>0 drops req once that many beats were seen.
  task automatic run_burst(input logic m, input logic [AW-1:0] b, input logic [CW-1:0] l,
                           input int abort_k);
    int t = 0, busy_t = -1, csn_t = -1, first_t = -1, last_t = -1, exit_t = -1;
    int beats = 0, csn_cnt = 0, exp_beats;
    bit done = 1'b0, ack_seen = 1'b0;
    exp_beats = (l == '0) ? 1 : int'(l);
    if (abort_k > 0 && abort_k + SYNC + 1 < exp_beats) exp_beats = abort_k + SYNC + 1;
    @(negedge clk);
    mode = m; base = b; len = l; req = 1'b1;
    while (!done && t < 400) begin
      @(posedge clk); #1; t++;
      if (busy && busy_t < 0) begin
        busy_t = t;
        // Burst parameters are latched at start; later changes must not matter.
        mode = ~m; base = AW'($urandom); len = CW'($urandom);
      end
      if (!csn) begin
        csn_cnt++;
        if (csn_t < 0) csn_t = t;
      end
      if (we || re) begin
        check("beat_addr", 32'(addr), (int'(b) + beats) % (1 << AW));
        check("beat_we", 32'(we), 32'(!m));
        check("beat_re", 32'(re), 32'(m));
        if (first_t < 0) first_t = t;
        last_t = t;
        beats++;
      end
      if (ack) ack_seen = 1'b1;
      if (abort_k == 0 && ack) begin exit_t = t; done = 1'b1; end
      if (abort_k > 0 && first_t >= 0 && !busy) begin exit_t = t; done = 1'b1; end
      if (abort_k > 0 && req && beats == abort_k) begin
        @(negedge clk);
        req = 1'b0;
      end
    end
    check("burst_done", 32'(done), 1);
    check("busy_latency", busy_t, SYNC + 1);
    check("csn_after_busy", csn_t, busy_t + 1);
    check("setup_cycles", first_t - csn_t, SETUP + 1);
    check("beat_count", beats, exp_beats);
    check("csn_low_cycles", csn_cnt, SETUP + 1 + exp_beats);
    check("gap_to_exit", exit_t - last_t, HOLD + 1);
    if (abort_k == 0) begin
      @(negedge clk);
      req = 1'b0;
      t = 0;
      while (ack && t < 50) begin
        @(posedge clk); #1; t++;
      end
      check("ack_drop_latency", t, SYNC + 1);
      check("busy_after_ack", 32'(busy), 0);
    end else begin
      check("ack_in_abort", 32'(ack_seen), 0);
    end
    check("csn_idle", 32'(csn), 1);
    check("st_idle", 32'(st), 0);
    $display("burst mode=%0d base=%0d len=%0d abort_at=%0d beats=%0d", m, b, l, abort_k, beats);
  endtask

  initial begin
    int t;
    int beats;
    rst = 1'b1; req = 1'b0; mode = 1'b0; base = '0; len = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_csn", 32'(csn), 1);
    check("reset_we", 32'(we), 0);
    check("reset_re", 32'(re), 0);
    check("reset_addr", 32'(addr), 0);
    check("reset_ack", 32'(ack), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_st", 32'(st), 0);
    @(negedge clk);
    rst = 1'b0;

    run_burst(1'b0, 5'd0, 6'd20, 0);
    run_burst(1'b1, 5'd30, 6'd4, 0);
    run_burst(1'b0, 5'd9, 6'd0, 0);
    run_burst(1'b0, 5'd3, 6'd20, 5);

    // Asynchronous reset in the middle of a write burst.
    @(negedge clk);
    mode = 1'b0; base = 5'd7; len = 6'd20; req = 1'b1;
    t = 0; beats = 0;
    while (beats < 3 && t < 100) begin
      @(posedge clk); #1; t++;
      if (we) beats++;
    end
    check("rst_reached_data", beats, 3);
    #2 rst = 1'b1;
    #1;
    check("midrst_csn", 32'(csn), 1);
    check("midrst_we", 32'(we), 0);
    check("midrst_re", 32'(re), 0);
    check("midrst_addr", 32'(addr), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ack", 32'(ack), 0);
    check("midrst_st", 32'(st), 0);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: second request one cycle after ack falls.
    run_burst(1'b1, 5'd12, 6'd7, 0);
    @(posedge clk);
    run_burst(1'b0, 5'd25, 6'd10, 0);

    for (int i = 0; i < 6; i++) begin
      run_burst(1'($urandom_range(0, 1)), AW'($urandom), CW'($urandom_range(0, 24)), 0);
    end
    run_burst(1'b1, AW'($urandom), 6'd16, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
